tetris_piece_ctrl: RTL
======================

TETRIS_PIECE_CTRL -- requirements
Module: tetris_piece_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  BLOCK, 20, block edge in pixels
  FIELD_W, 480, playfield width in pixels
  FIELD_H, 480, playfield height in pixels
  TICK_DIV, 3500000, clocks per game tick
  SPAWN_X, 280, spawn x in pixels
  GRAV_STEP, 5, base gravity in pixels per tick
  LOCK_TICKS, 2, ticks a grounded piece waits before locking
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  iVGA_CLK  in  1  sole clock
  reset  in  1  asynchronous active-high reset
  up, left, down, right  in  1 each  active-low buttons (up = restart)
  stop  in  1  collision below piece
  hit  in  1  collision beside piece; blocks lateral moves
  shape  in  3  shape code of the next piece
  level  in  2  speed level 0..3
  ref_x, ref_y  out  10 each  piece top-left in pixels
  change_shape  out  1  one-clock pulse when a piece locks
  start_over  out  1  one-clock pulse on restart
  state  out  2  0 = FALL, 1 = LOCK, 2 = SPAWN
REQ-003 The block SHALL use one clock, iVGA_CLK, with asynchronous active-high reset.

Function
REQ-004 The tick counter SHALL count 0..TICK_DIV-1 and wrap to 0. A tick is the clock on which count = TICK_DIV-1, giving one tick every TICK_DIV clocks.
REQ-005 The shape SHALL be latched into shape_q on reset and on each SPAWN clock only. Changing the shape input during FALL or LOCK has no effect.
REQ-006 Piece size (w, h) in blocks SHALL come from shape_q: 1 -> (4,1); 2 -> (1,4); any other code -> (2,2).
REQ-007 FLOOR SHALL equal FIELD_H - h*BLOCK, and XMAX SHALL equal FIELD_W - w*BLOCK.
REQ-008 Gravity SHALL be GRAV_STEP*(level+1) pixels per tick, with level sampled at the tick.
REQ-009 Outside ticks, ref_x, ref_y and state SHALL hold, except for the SPAWN transition (REQ-015).
REQ-010 In FALL, on a tick with up=0: pulse start_over, set ref_x=SPAWN_X and ref_y=0, latch shape_q, remain in FALL.
REQ-011 In FALL, on a tick with stop=1, or with ref_y=FLOOR at the tick: go to LOCK, load lock_cnt=LOCK_TICKS, and leave position unchanged.
REQ-012 In other FALL ticks, exactly one button acts, priority left > down > right:
  - left (requires hit=0, ref_x >= BLOCK): ref_x -= BLOCK
  - right (requires hit=0): ref_x = min(ref_x+BLOCK, XMAX)
  - ref_y = min(ref_y + gravity + (down pressed ? BLOCK : 0), FLOOR)
  - Sums SHALL be computed in 11 bits before clamping, with no wrap.
REQ-013 A blocked higher-priority button (e.g. left with hit=1) SHALL still consume priority, so lower buttons do not act on that tick.
REQ-014 In LOCK, on each tick:
  - up=0: behave as REQ-010 and return to FALL.
  - else if lock_cnt > 1: decrement lock_cnt.
  - else: pulse change_shape and go to SPAWN.
  - Movement SHALL be frozen throughout LOCK.
REQ-015 SPAWN SHALL last exactly one clock (no tick required): ref_x=SPAWN_X, ref_y=0, latch shape_q, then go to FALL.
REQ-016 change_shape and start_over SHALL be high for exactly one clock per event and never high simultaneously.
REQ-017 State encoding 3 SHALL be unreachable. If it is ever entered, the next clock SHALL go to SPAWN.

Reset
REQ-018 When reset is asserted, the block SHALL immediately set:
  - ref_x=SPAWN_X, ref_y=0, state=FALL
  - count=0, lock_cnt=0
  - change_shape=0, start_over=0
  - shape_q=shape
REQ-019 Reset asserted mid-LOCK or mid-tick SHALL abort the operation with no pulse emitted.

Verification (TICK_DIV=4, all other parameters at default)
REQ-020 Scenario: reset, shape=0, level=0, no buttons, 8 ticks -> ref_y steps 5,10,…,40 once every 4 clocks; ref_x stays 280.
REQ-021 Scenario: shape=1 with ref_y forced near the floor -> ref_y clamps to exactly 460. The next tick enters LOCK; two ticks later change_shape pulses one clock, then SPAWN -> ref=(280,0).
REQ-022 Scenario: left=0, right=0, hit=0 together -> only left acts, ref_x 280->260. Repeat with hit=1 -> ref_x stays 280 and right is also ignored.
REQ-023 Scenario: level=3, down=0 from ref_y=0 -> ref_y=40 after one tick. Shape=2 held down until grounded -> ref_y stops at exactly 400.
REQ-024 Scenario: up=0 during LOCK -> start_over pulses, ref=(280,0), state=FALL, and change_shape never pulses.
REQ-025 Scenario: reset asserted between ticks in LOCK -> outputs take reset values immediately, with no pulse.

Source files
------------

// File: rtl/tetris_piece_ctrl_if.sv
// Signal bundle between the game logic and the falling-piece controller.
//   master : game side, drives buttons, collision flags, next shape and level
//   slave  : controller side, drives piece position, event pulses and FSM state
// Signals:
//   up/left/down/right  active-low buttons (up = restart)
//   stop                collision below the piece
//   hit                 collision beside the piece, blocks lateral moves
//   shape               shape code of the next piece
//   level               speed level 0..3
//   ref_x/ref_y         piece top-left corner in pixels
//   change_shape        one-clock pulse when a piece locks
//   start_over          one-clock pulse on restart
//   state               0 = FALL, 1 = LOCK, 2 = SPAWN
interface tetris_piece_ctrl_if;
  logic       up;
  logic       left;
  logic       down;
  logic       right;
  logic       stop;
  logic       hit;
  logic [2:0] shape;
  logic [1:0] level;
  logic [9:0] ref_x;
  logic [9:0] ref_y;
  logic       change_shape;
  logic       start_over;
  logic [1:0] state;

  modport master (
    output up, left, down, right, stop, hit, shape, level,
    input  ref_x, ref_y, change_shape, start_over, state
  );

  modport slave (
    input  up, left, down, right, stop, hit, shape, level,
    output ref_x, ref_y, change_shape, start_over, state
  );
endinterface

// File: rtl/tetris_piece_ctrl.sv
// Falling-piece controller: moves the active piece once per game tick under
// gravity and button control, waits LOCK_TICKS ticks once grounded, then
// requests a new piece and respawns it at the top.
// Ports:
//   iVGA_CLK  sole clock
//   reset     asynchronous active-high reset
//   bus       tetris_piece_ctrl_if.slave (buttons, collisions, shape/level in;
//             position, change_shape/start_over pulses and state out)
module tetris_piece_ctrl #(
  parameter int unsigned BLOCK      = 20,
  parameter int unsigned FIELD_W    = 480,
  parameter int unsigned FIELD_H    = 480,
  parameter int unsigned TICK_DIV   = 3500000,
  parameter int unsigned SPAWN_X    = 280,
  parameter int unsigned GRAV_STEP  = 5,
  parameter int unsigned LOCK_TICKS = 2
) (
  input logic                 iVGA_CLK,
  input logic                 reset,
  tetris_piece_ctrl_if.slave  bus
);

  localparam int unsigned CntW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LockW = (LOCK_TICKS > 0) ? $clog2(LOCK_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    StFall  = 2'd0,
    StLock  = 2'd1,
    StSpawn = 2'd2,
    StBad   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q;
  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [9:0]        ref_x_q, ref_x_d;
  logic [9:0]        ref_y_q, ref_y_d;
  logic              change_shape_q, change_shape_d;
  logic              start_over_q, start_over_d;
  logic [2:0]        shape_q;
  logic              shape_load;

  logic              tick;
  int unsigned       w_blk, h_blk;
  logic [9:0]        floor_y, x_max;
  logic [10:0]       grav, x_sum, y_sum;
  logic [9:0]        x_right, y_next;
  logic              down_act;

  assign tick = (count_q == CntW'(TICK_DIV - 1));

  // Piece footprint comes from the latched shape, never the live input.
  always_comb begin
    w_blk = 2;
    h_blk = 2;
    if (shape_q == 3'd1) begin
      w_blk = 4;
      h_blk = 1;
    end else if (shape_q == 3'd2) begin
      w_blk = 1;
      h_blk = 4;
    end
    floor_y = 10'(FIELD_H - h_blk * BLOCK);
    x_max   = 10'(FIELD_W - w_blk * BLOCK);
  end

  // Down only adds its boost when left is not pressed (left has priority).
  assign down_act = bus.left && !bus.down;
  assign grav     = 11'(GRAV_STEP) * ({9'd0, bus.level} + 11'd1);
  assign y_sum    = {1'b0, ref_y_q} + grav + (down_act ? 11'(BLOCK) : 11'd0);
  assign x_sum    = {1'b0, ref_x_q} + 11'(BLOCK);
  assign y_next   = (y_sum > {1'b0, floor_y}) ? floor_y : y_sum[9:0];
  assign x_right  = (x_sum > {1'b0, x_max}) ? x_max : x_sum[9:0];

  // State register.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      state_q <= StFall;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; shape is sampled live while reset is held.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      count_q        <= '0;
      lock_cnt_q     <= '0;
      ref_x_q        <= 10'(SPAWN_X);
      ref_y_q        <= 10'd0;
      change_shape_q <= 1'b0;
      start_over_q   <= 1'b0;
      shape_q        <= bus.shape;
    end else begin
      count_q        <= tick ? '0 : count_q + CntW'(1);
      lock_cnt_q     <= lock_cnt_d;
      ref_x_q        <= ref_x_d;
      ref_y_q        <= ref_y_d;
      change_shape_q <= change_shape_d;
      start_over_q   <= start_over_d;
      if (shape_load) begin
        shape_q <= bus.shape;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d        = state_q;
    lock_cnt_d     = lock_cnt_q;
    ref_x_d        = ref_x_q;
    ref_y_d        = ref_y_q;
    change_shape_d = 1'b0;
    start_over_d   = 1'b0;
    shape_load     = 1'b0;

    unique case (state_q)
      StFall: begin
        if (tick) begin
          if (!bus.up) begin
            start_over_d = 1'b1;
            ref_x_d      = 10'(SPAWN_X);
            ref_y_d      = 10'd0;
            shape_load   = 1'b1;
          end else if (bus.stop || (ref_y_q == floor_y)) begin
            state_d    = StLock;
            lock_cnt_d = LockW'(LOCK_TICKS);
          end else begin
            // A pressed but blocked button still takes priority over the rest.
            if (!bus.left) begin
              if (!bus.hit && (ref_x_q >= 10'(BLOCK))) begin
                ref_x_d = ref_x_q - 10'(BLOCK);
              end
            end else if (bus.down && !bus.right && !bus.hit) begin
              ref_x_d = x_right;
            end
            ref_y_d = y_next;
          end
        end
      end
      StLock: begin
        if (tick) begin
          if (!bus.up) begin
            start_over_d = 1'b1;
            ref_x_d      = 10'(SPAWN_X);
            ref_y_d      = 10'd0;
            shape_load   = 1'b1;
            state_d      = StFall;
          end else if (lock_cnt_q > LockW'(1)) begin
            lock_cnt_d = lock_cnt_q - LockW'(1);
          end else begin
            change_shape_d = 1'b1;
            state_d        = StSpawn;
          end
        end
      end
      StSpawn: begin
        ref_x_d    = 10'(SPAWN_X);
        ref_y_d    = 10'd0;
        shape_load = 1'b1;
        state_d    = StFall;
      end
      StBad: begin
        state_d = StSpawn;
      end
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.ref_x        = ref_x_q;
    bus.ref_y        = ref_y_q;
    bus.change_shape = change_shape_q;
    bus.start_over   = start_over_q;
    bus.state        = state_q;
  end

endmodule
